// File: rtl/wave_capture_if.sv
// Signal bundle between the wave capture block and its neighbours: the audio
// sample stream in, the RAM write port and display half-select out.
interface wave_capture_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 9
);
    logic                           sample_valid;
    logic signed [SAMPLE_WIDTH-1:0] sample_in;
    logic                           display_idle;
    logic                           write_enable;
    logic [ADDR_WIDTH-1:0]          write_address;
    logic [7:0]                     write_sample;
    logic                           read_index;

    modport master (
        output sample_valid, sample_in, display_idle,
        input  write_enable, write_address, write_sample, read_index
    );

    modport slave (
        input  sample_valid, sample_in, display_idle,
        output write_enable, write_address, write_sample, read_index
    );
endinterface

// File: rtl/wave_capture.sv
// Trigger-aligned capture of an audio stream into the half of a double-buffered
// sample RAM that the wave display is not currently reading.
module wave_capture #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int NUM_SAMPLES  = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    wave_capture_if.slave  bus
);
    localparam int IDX_W  = $clog2(NUM_SAMPLES);
    localparam int ADDR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_ARMED,
        ST_ACTIVE,
        ST_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic               prevNeg_q, prevNeg_d;
    logic               readIndex_q, readIndex_d;
    logic               writeEnable_q, writeEnable_d;
    logic [ADDR_W-1:0]  writeAddress_q, writeAddress_d;
    logic [7:0]         writeSample_q, writeSample_d;

    logic               crossing;
    logic [7:0]         converted;

    // Top byte of the signed sample with the sign flipped gives offset binary.
    assign converted = {~bus.sample_in[SAMPLE_WIDTH-1], bus.sample_in[SAMPLE_WIDTH-2 -: 7]};
    assign crossing  = bus.sample_valid && prevNeg_q && !bus.sample_in[SAMPLE_WIDTH-1];

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        readIndex_d    = readIndex_q;
        writeEnable_d  = 1'b0;
        writeAddress_d = writeAddress_q;
        writeSample_d  = writeSample_q;
        prevNeg_d      = bus.sample_valid ? bus.sample_in[SAMPLE_WIDTH-1] : prevNeg_q;

        unique case (state_q)
            ST_ARMED: begin
                if (crossing) begin
                    writeEnable_d  = 1'b1;
                    writeAddress_d = {~readIndex_q, {IDX_W{1'b0}}};
                    writeSample_d  = converted;
                    count_d        = IDX_W'(1);
                    state_d        = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (bus.sample_valid) begin
                    writeEnable_d  = 1'b1;
                    writeAddress_d = {~readIndex_q, count_q};
                    writeSample_d  = converted;
                    if (count_q == IDX_W'(NUM_SAMPLES - 1)) begin
                        count_d = '0;
                        state_d = ST_WAIT;
                    end else begin
                        count_d = count_q + IDX_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                // Idle wins over a simultaneous crossing; a fresh one is needed once armed.
                if (bus.display_idle) begin
                    readIndex_d = ~readIndex_q;
                    state_d     = ST_ARMED;
                end
            end
            default: state_d = ST_ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_ARMED;
            count_q        <= '0;
            prevNeg_q      <= 1'b0;
            readIndex_q    <= 1'b0;
            writeEnable_q  <= 1'b0;
            writeAddress_q <= '0;
            writeSample_q  <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            prevNeg_q      <= prevNeg_d;
            readIndex_q    <= readIndex_d;
            writeEnable_q  <= writeEnable_d;
            writeAddress_q <= writeAddress_d;
            writeSample_q  <= writeSample_d;
        end
    end

    assign bus.write_enable  = writeEnable_q;
    assign bus.write_address = writeAddress_q;
    assign bus.write_sample  = writeSample_q;
    assign bus.read_index    = readIndex_q;
endmodule

// File: tb/tb_wave_capture.sv
// Directed scoreboard bench for wave_capture: stimulus queues expected RAM
// writes, a negedge monitor pops and compares every write the DUT issues.
module tb_wave_capture;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    wave_capture_if bus ();

    wave_capture dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] expQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One valid sample, then 'gap' quiet cycles; a zero gap keeps valid high back-to-back.
    task automatic applyStimulus(input logic signed [15:0] s, input logic idle, input int gap,
                                 input logic expWrite, input logic [8:0] expAddr, input logic [7:0] expData);
        if (expWrite)
            expQ.push_back({expAddr, expData});
        bus.sample_valid = 1'b1;
        bus.sample_in    = s;
        bus.display_idle = idle;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput(name, expQ.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.write_enable === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected write: got addr 0x%0h data 0x%0h, expected no write",
                         bus.write_address, bus.write_sample);
            end else begin
                checkOutput("write addr/data", {bus.write_address, bus.write_sample}, expQ.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] idx;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        bus.display_idle = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset write_enable", bus.write_enable, 0);
        checkOutput("reset write_address", bus.write_address, 0);
        checkOutput("reset write_sample", bus.write_sample, 0);
        checkOutput("reset read_index", bus.read_index, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Trigger: only the negative-to-positive step writes.
        applyStimulus(16'sd100, 1'b0, 1, 1'b0, 9'h000, 8'h00);
        applyStimulus(-16'sd5,  1'b0, 1, 1'b0, 9'h000, 8'h00);
        applyStimulus(16'sd3,   1'b0, 0, 1'b1, 9'h100, 8'h80);

        for (int i = 1; i < 256; i++)
            applyStimulus(16'sh7FFF, 1'b0, 0, 1'b1, 9'h100 + 9'(i), 8'hFF);
        drain("frame1 drain");
        checkOutput("frame1 read_index", bus.read_index, 0);

        // WAIT: crossings without display_idle are ignored.
        applyStimulus(-16'sd100, 1'b0, 1, 1'b0, 9'h000, 8'h00);
        applyStimulus(16'sd50,   1'b0, 1, 1'b0, 9'h000, 8'h00);
        drain("wait drain");
        checkOutput("wait read_index", bus.read_index, 0);

        bus.display_idle = 1'b1;
        @(posedge clk); #1;
        bus.display_idle = 1'b0;
        checkOutput("flip read_index", bus.read_index, 1);

        applyStimulus(-16'sd100, 1'b0, 0, 1'b0, 9'h000, 8'h00);
        applyStimulus(16'sd50,   1'b0, 0, 1'b1, 9'h000, 8'h80);

        applyStimulus(-16'sd32768, 1'b0, 0, 1'b1, 9'h001, 8'h00);
        applyStimulus(-16'sd1,     1'b0, 0, 1'b1, 9'h002, 8'h7F);
        applyStimulus(16'sd0,      1'b0, 0, 1'b1, 9'h003, 8'h80);
        applyStimulus(16'sd256,    1'b0, 0, 1'b1, 9'h004, 8'h81);

        // Gapped samples with display_idle held high through ACTIVE.
        for (int i = 5; i < 256; i++) begin
            idx = 8'(i);
            if (i == 128)
                checkOutput("mid-frame read_index", bus.read_index, 1);
            applyStimulus({idx, 8'h00}, 1'b1, 3, 1'b1, {1'b0, idx}, idx ^ 8'h80);
        end
        bus.display_idle = 1'b0;
        drain("frame2 drain");
        checkOutput("frame2 flip read_index", bus.read_index, 0);

        // Partial frame into half 1, then asynchronous reset.
        applyStimulus(-16'sd1, 1'b0, 0, 1'b0, 9'h000, 8'h00);
        applyStimulus(16'sd1,  1'b0, 0, 1'b1, 9'h100, 8'h80);
        for (int i = 1; i < 100; i++)
            applyStimulus(16'sh1234, 1'b0, 0, 1'b1, 9'h100 + 9'(i), 8'h92);
        drain("partial drain");

        bus.sample_valid = 1'b1;
        bus.sample_in    = 16'sh1234;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        checkOutput("pre-reset write_enable", bus.write_enable, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async reset write_enable", bus.write_enable, 0);
        checkOutput("async reset write_address", bus.write_address, 0);
        checkOutput("async reset write_sample", bus.write_sample, 0);
        checkOutput("async reset read_index", bus.read_index, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(16'sd5,  1'b0, 1, 1'b0, 9'h000, 8'h00);
        applyStimulus(-16'sd1, 1'b0, 1, 1'b0, 9'h000, 8'h00);
        applyStimulus(16'sd1,  1'b0, 1, 1'b1, 9'h100, 8'h80);
        drain("restart drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
